// File: rtl/vram_blit_ctrl.sv
// vram_blit_ctrl: fill/scroll engine sharing VRAM port A with the host bus.
// Host VRAM accesses always win; the engine stalls around them.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_wraddr/i_byteen/i_wren/i_wrdata   host write (byte address)
//   i_rdaddr/i_rden, o_rddata           host read, data one cycle later
//   o_vram_wea/addra/dina, i_vram_douta VRAM port A (1-cycle read latency)
//   o_busy                engine active
//   o_done_irq            one-cycle pulse on normal completion
module vram_blit_ctrl #(
  parameter int COLS = 80,
  parameter int ROWS = 50,
  parameter int AW   = 12,
  parameter int DW   = 24
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [15:0]   i_wraddr,
  input  logic [3:0]    i_byteen,
  input  logic          i_wren,
  input  logic [31:0]   i_wrdata,
  input  logic [15:0]   i_rdaddr,
  input  logic          i_rden,
  output logic [31:0]   o_rddata,
  output logic [2:0]    o_vram_wea,
  output logic [AW-1:0] o_vram_addra,
  output logic [DW-1:0] o_vram_dina,
  input  logic [DW-1:0] i_vram_douta,
  output logic          o_busy,
  output logic          o_done_irq
);

  localparam int NWORDS = COLS * ROWS;
  localparam logic [AW-1:0] LAST     = AW'(NWORDS - 1);
  localparam logic [AW-1:0] SCR_LAST = AW'(NWORDS - COLS - 1);
  localparam logic [AW-1:0] COLS_A   = AW'(COLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_SRD,
    S_SWR,
    S_SFIL
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] w_ptr_nx;
  logic          r_cap;
  logic          w_cap_nx;
  logic [DW-1:0] r_hold;
  logic [DW-1:0] w_hold_nx;
  logic [DW-1:0] r_fillv;
  logic          r_done;
  logic          r_done_irq;
  logic          r_rd_vram;
  logic [31:0]   r_rd_reg;

  logic          w_wr_vram;
  logic          w_rd_vram;
  logic          w_wr_reg;
  logic          w_rd_reg;
  logic          w_host;
  logic          w_cmd_wr;
  logic [1:0]    w_op;
  logic          w_abort;
  logic          w_start;
  logic          w_go;
  logic          w_stat_rd;
  logic          w_fillv_wr;
  logic          w_busy;
  logic          w_done_evt;
  logic [2:0]    w_eng_we;
  logic [AW-1:0] w_eng_addr;
  logic [DW-1:0] w_eng_din;
  logic [31:0]   w_reg_rdata;
  logic          w_unused;

  assign w_wr_vram  = i_wren & (i_wraddr[15:14] == 2'b00);
  assign w_rd_vram  = i_rden & (i_rdaddr[15:14] == 2'b00);
  assign w_wr_reg   = i_wren & (i_wraddr[15:14] == 2'b01);
  assign w_rd_reg   = i_rden & (i_rdaddr[15:14] == 2'b01);
  assign w_host     = w_wr_vram | w_rd_vram;
  assign w_cmd_wr   = w_wr_reg & (i_wraddr[3:2] == 2'd0);
  assign w_fillv_wr = w_wr_reg & (i_wraddr[3:2] == 2'd1);
  assign w_stat_rd  = w_rd_reg & (i_rdaddr[3:2] == 2'd2);
  assign w_op       = i_wrdata[1:0];
  assign w_abort    = w_cmd_wr & (w_op == 2'd3);
  assign w_busy     = (r_state != S_IDLE);
  assign w_start    = w_cmd_wr & ~w_busy
                    & ((w_op == 2'd1) | (w_op == 2'd2));
  // An abort takes effect in its own cycle: no engine access then.
  assign w_go       = ~w_host & ~w_abort;

  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_cap_nx   = r_cap;
    w_hold_nx  = r_hold;
    w_done_evt = 1'b0;
    w_eng_we   = 3'b000;
    w_eng_addr = r_ptr;
    w_eng_din  = r_fillv;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_ptr_nx   = '0;
          w_state_nx = (w_op == 2'd1) ? S_FILL : S_SRD;
        end
      end
      S_FILL, S_SFIL: begin
        w_eng_we = 3'b111;
        if (w_go) begin
          w_ptr_nx = r_ptr + 1'b1;
          if (r_ptr == LAST) begin
            w_state_nx = S_IDLE;
            w_done_evt = 1'b1;
          end
        end
      end
      S_SRD: begin
        w_eng_addr = r_ptr + COLS_A;
        if (w_go) begin
          w_cap_nx   = 1'b1;
          w_state_nx = S_SWR;
        end
      end
      S_SWR: begin
        w_eng_we  = 3'b111;
        // Read data is only on the port for one cycle; keep a copy
        // in case the host steals this slot.
        w_eng_din = r_cap ? i_vram_douta : r_hold;
        if (r_cap) begin
          w_hold_nx = i_vram_douta;
          w_cap_nx  = 1'b0;
        end
        if (w_go) begin
          w_ptr_nx   = r_ptr + 1'b1;
          w_state_nx = (r_ptr == SCR_LAST) ? S_SFIL : S_SRD;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    if (w_abort) begin
      w_state_nx = S_IDLE;
    end
  end

  always_comb begin
    w_reg_rdata = '0;
    if (w_rd_reg) begin
      unique case (i_rdaddr[3:2])
        2'd1:    w_reg_rdata = {{(32-DW){1'b0}}, r_fillv};
        2'd2:    w_reg_rdata = {30'd0, r_done, w_busy};
        default: w_reg_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_cap      <= 1'b0;
      r_hold     <= '0;
      r_fillv    <= '0;
      r_done     <= 1'b0;
      r_done_irq <= 1'b0;
      r_rd_vram  <= 1'b0;
      r_rd_reg   <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_ptr      <= w_ptr_nx;
      r_cap      <= w_cap_nx;
      r_hold     <= w_hold_nx;
      r_done_irq <= w_done_evt;
      if (w_stat_rd || w_start) begin
        r_done <= 1'b0;
      end
      if (w_done_evt) begin
        r_done <= 1'b1;
      end
      if (w_fillv_wr) begin
        for (int b = 0; b < 3; b++) begin
          if (i_byteen[b]) begin
            r_fillv[8*b +: 8] <= i_wrdata[8*b +: 8];
          end
        end
      end
      // Register values are captured at read time so a STATUS read
      // returns DONE before the read clears it.
      if (i_rden) begin
        r_rd_vram <= w_rd_vram;
        r_rd_reg  <= w_reg_rdata;
      end
    end
  end

  always_comb begin
    if (w_rd_vram) begin
      o_vram_addra = i_rdaddr[AW+1:2];
      o_vram_wea   = 3'b000;
    end else if (w_wr_vram) begin
      o_vram_addra = i_wraddr[AW+1:2];
      o_vram_wea   = i_byteen[2:0];
    end else begin
      o_vram_addra = w_eng_addr;
      o_vram_wea   = w_go ? w_eng_we : 3'b000;
    end
  end

  assign o_vram_dina = w_host ? i_wrdata[DW-1:0] : w_eng_din;
  assign o_rddata    = r_rd_vram ? {{(32-DW){1'b0}}, i_vram_douta}
                                 : r_rd_reg;
  assign o_busy      = w_busy;
  assign o_done_irq  = r_done_irq;

  assign w_unused = ^{i_wraddr[1:0], i_rdaddr[1:0],
                      i_wrdata[31:24], i_byteen[3]};

endmodule

// File: tb/tb_vram_blit_ctrl.sv
// tb_vram_blit_ctrl: randomized bench with a cycle-level behavioural
// model of busy/irq/status and whole-screen expectations for VRAM.
module tb_vram_blit_ctrl;

  localparam int AW = 12;
  localparam int DW = 24;
  localparam logic [15:0] A_CMD  = 16'h4000;
  localparam logic [15:0] A_FILL = 16'h4004;
  localparam logic [15:0] A_STAT = 16'h4008;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   wraddr;
  logic [3:0]    byteen;
  logic          wren;
  logic [31:0]   wrdata;
  logic [15:0]   rdaddr;
  logic          rden;
  logic [31:0]   rddata;
  logic [2:0]    wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic [DW-1:0] douta;
  logic          busy;
  logic          irq;

  always #5 clk = ~clk;

  vram_blit_ctrl #(
    .COLS(80), .ROWS(50), .AW(AW), .DW(DW)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wraddr(wraddr), .i_byteen(byteen),
    .i_wren(wren), .i_wrdata(wrdata),
    .i_rdaddr(rdaddr), .i_rden(rden),
    .o_rddata(rddata), .o_vram_wea(wea),
    .o_vram_addra(addra), .o_vram_dina(dina),
    .i_vram_douta(douta),
    .o_busy(busy), .o_done_irq(irq)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;
  int irq_cnt = 0;
  int irq_cyc = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // VRAM port A: read-first block RAM.
  logic [23:0] mem [4096];
  logic        preload = 1'b0;
  always @(posedge clk) begin
    if (preload) begin
      for (int a = 0; a < 4096; a++) mem[a] <= 24'(a);
    end else begin
      for (int b = 0; b < 3; b++)
        if (wea[b]) mem[addra][8*b +: 8] <= dina[8*b +: 8];
    end
    douta <= mem[addra];
  end

  // Behavioural model: an op is a number of access slots; each cycle
  // not taken by the host consumes one slot.
  bit          m_busy = 0, m_done = 0, m_irq = 0, m_rd_pend = 0;
  logic [23:0] m_fillv = '0;
  logic [31:0] m_rd_exp = '0;
  int          m_rem = 0;
  bit          h_own, c_cmd;
  logic [1:0]  c_op;

  always @(posedge clk) begin
    cyc++;
    m_irq = 1'b0;
    if (rst) begin
      m_busy = 0; m_done = 0; m_fillv = '0;
      m_rd_pend = 1; m_rd_exp = '0; m_rem = 0;
    end else begin
      h_own = (rden && rdaddr[15:14] == 2'b00)
           || (wren && wraddr[15:14] == 2'b00);
      c_cmd = wren && wraddr[15:14] == 2'b01 && wraddr[3:2] == 2'd0;
      c_op  = wrdata[1:0];
      m_rd_pend = rden;
      if (rden) begin
        m_rd_exp = '0;
        if (rdaddr[15:14] == 2'b00)
          m_rd_exp = {8'h00, mem[rdaddr[13:2]]};
        else if (rdaddr[15:14] == 2'b01 && rdaddr[3:2] == 2'd1)
          m_rd_exp = {8'h00, m_fillv};
        else if (rdaddr[15:14] == 2'b01 && rdaddr[3:2] == 2'd2) begin
          m_rd_exp = {30'd0, m_done, m_busy};
          m_done = 0;
        end
      end
      if (m_busy) begin
        if (c_cmd && c_op == 2'd3) m_busy = 0;
        else if (!h_own) begin
          m_rem--;
          if (m_rem == 0) begin
            m_busy = 0; m_irq = 1; m_done = 1;
          end
        end
      end else if (c_cmd && (c_op == 2'd1 || c_op == 2'd2)) begin
        m_busy = 1; m_done = 0;
        m_rem = (c_op == 2'd1) ? 4000 : 7920;
      end
      if (wren && wraddr[15:14] == 2'b01 && wraddr[3:2] == 2'd1)
        for (int b = 0; b < 3; b++)
          if (byteen[b]) m_fillv[8*b +: 8] = wrdata[8*b +: 8];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done_irq", 32'(irq), 32'(m_irq));
      if (m_rd_pend) check("rddata", rddata, m_rd_exp);
      if (irq) begin
        irq_cnt++;
        irq_cyc = cyc;
      end
      if (rden && rdaddr[15:14] == 2'b00) begin
        check("host_rd_addr", 32'(addra), 32'(rdaddr[13:2]));
        check("host_rd_wea", 32'(wea), 0);
      end else if (wren && wraddr[15:14] == 2'b00) begin
        check("host_wr_wea", 32'(wea), 32'(byteen[2:0]));
        check("host_wr_addr", 32'(addra), 32'(wraddr[13:2]));
        check("host_wr_din", 32'(dina), 32'(wrdata[23:0]));
      end else if (!m_busy) begin
        check("idle_wea", 32'(wea), 0);
      end
    end
  end

  task automatic step(input logic w, input logic [15:0] wa,
                      input logic [31:0] wd, input logic [3:0] be,
                      input logic r, input logic [15:0] ra);
    wren = w; wraddr = wa; wrdata = wd; byteen = be;
    rden = r; rdaddr = ra;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, '0, 0, '0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d,
                    input logic [3:0] be);
    step(1, a, d, be, 0, '0);
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    step(0, '0, '0, '0, 1, a);
    d = rddata;
  endtask

  function automatic logic [15:0] vaddr(input int w);
    return 16'(w * 4);
  endfunction

  task automatic do_preload();
    preload = 1'b1;
    idle(1);
    preload = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 20000) begin
      idle(1);
      n++;
    end
    if (n >= 20000) check({nm, "_timeout"}, 32'(busy), 0);
  endtask

  task automatic chk_mem(input string nm, input bit scroll,
                         input int nfill, input logic [23:0] fv,
                         input int lim);
    int bad = 0;
    logic [23:0] e;
    for (int a = 0; a < lim; a++) begin
      if (scroll) e = (a < 3920) ? 24'(a + 80) : (a < 4000 ? fv : 24'(a));
      else        e = (a < nfill) ? fv : 24'(a);
      if (mem[a] !== e) bad++;
    end
    check(nm, bad, 0);
  endtask

  task automatic rand_run(input logic [1:0] op);
    logic [23:0] fv;
    logic [31:0] d;
    int t, own, n, r, ic;
    do_preload();
    fv = 24'($urandom);
    wr(A_FILL, {8'h00, fv}, 4'hF);
    ic = irq_cnt;
    t = cyc;
    wr(A_CMD, {30'd0, op}, 4'hF);
    own = 0;
    n = 0;
    while (busy && n < 20000) begin
      r = $urandom_range(0, 19);
      if (r < 3) begin
        own++;
        rd(vaddr(4000 + $urandom_range(0, 89)), d);
      end else if (r == 3) begin
        rd({1'b1, 15'($urandom)}, d);
      end else if (r == 4) begin
        own++;
        wr(vaddr(4091 + $urandom_range(0, 4)), $urandom, 4'($urandom));
      end else if (r == 5) begin
        rd(A_FILL, d);
      end else if (r == 6) begin
        rd(A_STAT, d);
      end else begin
        idle(1);
      end
      n++;
    end
    if (n >= 20000) check("rand_timeout", 32'(busy), 0);
    check("rand_irq_count", irq_cnt, ic + 1);
    check("rand_done_time", irq_cyc - t, (op == 2'd1 ? 4001 : 7921) + own);
    chk_mem("rand_data", op == 2'd2, 4000, fv, 4091);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] lv;
    int t, ic;
    rst = 1'b1;
    idle(3);
    chk_en = 1'b1;
    check("reset_busy", 32'(busy), 0);
    check("reset_irq", 32'(irq), 0);
    check("reset_rddata", rddata, 0);
    rst = 1'b0;
    rd(A_STAT, d);
    check("reset_status", d, 0);
    rd(A_FILL, d);
    check("reset_fillv", d, 0);

    // FILL from reset
    do_preload();
    wr(A_FILL, 32'h0021F041, 4'hF);
    ic = irq_cnt;
    t = cyc;
    wr(A_CMD, 32'd1, 4'hF);
    check("fill_busy_rise", 32'(busy), 1);
    wait_idle("fill");
    check("fill_done_time", irq_cyc - t, 4001);
    check("fill_irq_count", irq_cnt, ic + 1);
    check("fill_w0", 32'(mem[0]), 32'h21F041);
    check("fill_w2000", 32'(mem[2000]), 32'h21F041);
    check("fill_w3999", 32'(mem[3999]), 32'h21F041);
    check("fill_w4000", 32'(mem[4000]), 32'd4000);
    rd(A_STAT, d);
    check("status_first", d, 32'h2);
    rd(A_STAT, d);
    check("status_second", d, 32'h0);
    wr(A_CMD, 32'd0, 4'hF);
    idle(3);
    check("noop_busy", 32'(busy), 0);

    // SCROLL, with a partial FILLV write
    do_preload();
    wr(A_FILL, 32'h00123456, 4'hF);
    wr(A_FILL, 32'h00AABBCC, 4'b0101);
    rd(A_FILL, d);
    check("fillv_byteen", d, 32'h00AA34CC);
    t = cyc;
    wr(A_CMD, 32'd2, 4'hF);
    wait_idle("scroll");
    check("scroll_done_time", irq_cyc - t, 7921);
    chk_mem("scroll_data", 1, 0, 24'hAA34CC, 4096);

    // Host contention during SCROLL
    do_preload();
    wr(A_FILL, 32'h00555AAA, 4'hF);
    t = cyc;
    wr(A_CMD, 32'd2, 4'hF);
    idle(1);
    for (int i = 0; i < 50; i++) begin
      rd(vaddr(4000 + i), d);
      check("cont_rd", d, 32'(4000 + i));
      idle(2);
    end
    idle(50);
    lv = '0;
    for (int i = 0; i < 30; i++) begin
      lv = $urandom;
      wr(vaddr(4090), lv, 4'hF);
    end
    wait_idle("cont");
    check("cont_done_time", irq_cyc - t, 7921 + 80);
    chk_mem("cont_data", 1, 0, 24'h555AAA, 4090);
    check("cont_w4090", 32'(mem[4090]), {8'h00, lv[23:0]});

    // Randomized traffic
    rand_run(2'd1);
    rand_run(2'd2);

    // Ignored command while busy
    do_preload();
    wr(A_FILL, 32'h00C0FFEE, 4'hF);
    ic = irq_cnt;
    t = cyc;
    wr(A_CMD, 32'd1, 4'hF);
    idle(49);
    wr(A_CMD, 32'd2, 4'hF);
    wait_idle("ign");
    check("ign_done_time", irq_cyc - t, 4001);
    idle(10);
    check("ign_busy_after", 32'(busy), 0);
    check("ign_irq_count", irq_cnt, ic + 1);
    chk_mem("ign_data", 0, 4000, 24'hC0FFEE, 4096);

    // ABORT
    do_preload();
    wr(A_FILL, 32'h00777777, 4'hF);
    rd(A_STAT, d);
    ic = irq_cnt;
    wr(A_CMD, 32'd1, 4'hF);
    idle(99);
    wr(A_CMD, 32'd3, 4'hF);
    check("abort_busy", 32'(busy), 0);
    idle(5);
    check("abort_irq_count", irq_cnt, ic);
    rd(A_STAT, d);
    check("abort_status", d, 32'h0);
    chk_mem("abort_data", 0, 99, 24'h777777, 4096);

    // Reset mid-FILL
    wr(A_FILL, 32'h00ABCDEF, 4'hF);
    wr(A_CMD, 32'd1, 4'hF);
    idle(499);
    rst = 1'b1;
    idle(1);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_rddata", rddata, 0);
    rst = 1'b0;
    rd(A_FILL, d);
    check("midrst_fillv", d, 0);
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
